// File: rtl/arbiter_pkg.sv
// Shared types and default sizing for the L1 I/D cache to memory arbiter.
package arbiter_pkg;

  localparam int unsigned WORDSIZE_DEF = 64;
  localparam int unsigned TAGWIDTH_DEF = 13;
  localparam int unsigned BEATS_DEF    = 8;

  typedef enum logic [1:0] {
    OWNER_NONE   = 2'd0,
    OWNER_ICACHE = 2'd1,
    OWNER_DCACHE = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Two-way grant picker: round robin on ties, or fixed D-cache priority
// when ARB_DCACHE_PRIORITY_EN is defined.
module arb_rr_picker
  import arbiter_pkg::*;
(
  input  logic   icache_req_i,
  input  logic   dcache_req_i,
  input  owner_t last_grant_i,
  output owner_t grant_o
);

  always_comb begin
    grant_o = OWNER_NONE;
    if (icache_req_i && dcache_req_i) begin
`ifdef ARB_DCACHE_PRIORITY_EN
      grant_o = OWNER_DCACHE;
`else
      grant_o = (last_grant_i == OWNER_ICACHE) ? OWNER_DCACHE : OWNER_ICACHE;
`endif
    end else if (icache_req_i) begin
      grant_o = OWNER_ICACHE;
    end else if (dcache_req_i) begin
      grant_o = OWNER_DCACHE;
    end
  end

`ifdef ARB_DCACHE_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the memory bus between the L1 I- and D-caches: one line fill at a
// time, response burst routed to the owner only. Option: ARB_DCACHE_PRIORITY_EN.
module cache_mem_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned WORDSIZE = WORDSIZE_DEF,
  parameter int unsigned TAGWIDTH = TAGWIDTH_DEF,
  parameter int unsigned BEATS    = BEATS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                icache_reqcyc,
  input  logic [WORDSIZE-1:0] icache_req,
  input  logic [TAGWIDTH-1:0] icache_reqtag,
  output logic                icache_reqack,
  output logic                icache_respcyc,
  output logic [WORDSIZE-1:0] icache_resp,
  output logic [TAGWIDTH-1:0] icache_resptag,
  input  logic                icache_respack,
  input  logic                dcache_reqcyc,
  input  logic [WORDSIZE-1:0] dcache_req,
  input  logic [TAGWIDTH-1:0] dcache_reqtag,
  output logic                dcache_reqack,
  output logic                dcache_respcyc,
  output logic [WORDSIZE-1:0] dcache_resp,
  output logic [TAGWIDTH-1:0] dcache_resptag,
  input  logic                dcache_respack,
  output logic                mem_reqcyc,
  output logic [WORDSIZE-1:0] mem_req,
  output logic [TAGWIDTH-1:0] mem_reqtag,
  input  logic                mem_reqack,
  input  logic                mem_respcyc,
  input  logic [WORDSIZE-1:0] mem_resp,
  input  logic [TAGWIDTH-1:0] mem_resptag,
  output logic                mem_respack
);

  localparam int unsigned CNTW = $clog2(BEATS) + 1;

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              last_grant_q, last_grant_d;
  owner_t              grant;
  logic [CNTW-1:0]     beat_cnt_q, beat_cnt_d;
  logic                mem_reqcyc_q, mem_reqcyc_d;
  logic [WORDSIZE-1:0] mem_req_q, mem_req_d;
  logic [TAGWIDTH-1:0] mem_reqtag_q, mem_reqtag_d;
  logic                icache_reqack_q, icache_reqack_d;
  logic                dcache_reqack_q, dcache_reqack_d;
  logic                route_i, route_d, beat_fire;

  arb_rr_picker u_picker (
    .icache_req_i (icache_reqcyc),
    .dcache_req_i (dcache_reqcyc),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Response path is a zero-latency mux, open only to the owner during RESP.
  assign route_i        = (state_q == ARB_RESP) && (owner_q == OWNER_ICACHE);
  assign route_d        = (state_q == ARB_RESP) && (owner_q == OWNER_DCACHE);
  assign mem_respack    = (route_i && icache_respack) || (route_d && dcache_respack);
  assign beat_fire      = mem_respcyc && mem_respack;
  assign icache_respcyc = route_i && mem_respcyc;
  assign icache_resp    = route_i ? mem_resp : '0;
  assign icache_resptag = route_i ? mem_resptag : '0;
  assign dcache_respcyc = route_d && mem_respcyc;
  assign dcache_resp    = route_d ? mem_resp : '0;
  assign dcache_resptag = route_d ? mem_resptag : '0;

  assign mem_reqcyc    = mem_reqcyc_q;
  assign mem_req       = mem_req_q;
  assign mem_reqtag    = mem_reqtag_q;
  assign icache_reqack = icache_reqack_q;
  assign dcache_reqack = dcache_reqack_q;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    beat_cnt_d      = beat_cnt_q;
    mem_reqcyc_d    = mem_reqcyc_q;
    mem_req_d       = mem_req_q;
    mem_reqtag_d    = mem_reqtag_q;
    icache_reqack_d = 1'b0;
    dcache_reqack_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant != OWNER_NONE) begin
          state_d      = ARB_REQ;
          owner_d      = grant;
          last_grant_d = grant;
          mem_reqcyc_d = 1'b1;
          if (grant == OWNER_ICACHE) begin
            mem_req_d    = icache_req;
            mem_reqtag_d = icache_reqtag;
          end else begin
            mem_req_d    = dcache_req;
            mem_reqtag_d = dcache_reqtag;
          end
        end
      end
      ARB_REQ: begin
        if (mem_reqack) begin
          state_d         = ARB_RESP;
          mem_reqcyc_d    = 1'b0;
          beat_cnt_d      = '0;
          icache_reqack_d = (owner_q == OWNER_ICACHE);
          dcache_reqack_d = (owner_q == OWNER_DCACHE);
        end
      end
      ARB_RESP: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + CNTW'(1);
          if (beat_cnt_q == CNTW'(BEATS - 1)) begin
            state_d = ARB_IDLE;
            owner_d = OWNER_NONE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWNER_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ARB_IDLE;
      owner_q         <= OWNER_NONE;
      last_grant_q    <= OWNER_DCACHE;
      beat_cnt_q      <= '0;
      mem_reqcyc_q    <= 1'b0;
      mem_req_q       <= '0;
      mem_reqtag_q    <= '0;
      icache_reqack_q <= 1'b0;
      dcache_reqack_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      beat_cnt_q      <= beat_cnt_d;
      mem_reqcyc_q    <= mem_reqcyc_d;
      mem_req_q       <= mem_req_d;
      mem_reqtag_q    <= mem_reqtag_d;
      icache_reqack_q <= icache_reqack_d;
      dcache_reqack_q <= dcache_reqack_d;
    end
  end

endmodule
